// File: rtl/fpu_operand_unpacker.sv
// Two-stage IEEE-754 single-precision operand decoder: sign, unbiased exponent and
// normalized [xx.xxxx...] fraction (2 integer bits), with special-value classification.
module fpu_operand_unpacker #(
    parameter int EXP_WIDTH = 10
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [31:0]                 operand,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        sign,
    output logic signed [EXP_WIDTH-1:0] exponent,
    output logic [31:0]                 fraction,
    output logic                        is_zero,
    output logic                        is_subnormal,
    output logic                        is_inf,
    output logic                        is_nan,
    output logic                        is_snan
);

    typedef enum logic [2:0] {
        CLS_NORMAL,
        CLS_ZERO,
        CLS_SUB,
        CLS_INF,
        CLS_NAN
    } op_class_e;

    localparam logic [EXP_WIDTH-1:0] BIAS    = EXP_WIDTH'(127);
    localparam logic [EXP_WIDTH-1:0] EXP_MAX = EXP_WIDTH'(128);

    // Leading zeros of a 23-bit mantissa; 23 for an all-zero input.
    function automatic logic [4:0] lzc23(input logic [22:0] m);
        lzc23 = 5'd23;
        for (int i = 0; i < 23; i++) begin
            if (m[i]) lzc23 = 5'(22 - i);
        end
    endfunction

    logic        s1_valid;
    logic        s1_sign;
    logic [7:0]  s1_exp;
    logic [22:0] s1_man;
    logic [4:0]  s1_lzc;
    op_class_e   s1_class;

    logic        s2_valid;
    logic        s2_advance;

    logic [7:0]  op_exp;
    logic [22:0] op_man;
    op_class_e   d_class;

    assign op_exp = operand[30:23];
    assign op_man = operand[22:0];

    assign s2_advance = !s2_valid || out_ready;
    assign in_ready   = !s1_valid || s2_advance;
    assign out_valid  = s2_valid;

    // NOTE: every signal driven from always_comb gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        d_class = CLS_NORMAL;
        if (op_exp == 8'h00) begin
            d_class = (op_man == 23'd0) ? CLS_ZERO : CLS_SUB;
        end else if (op_exp == 8'hFF) begin
            d_class = (op_man == 23'd0) ? CLS_INF : CLS_NAN;
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_exp   <= '0;
            s1_man   <= '0;
            s1_lzc   <= '0;
            s1_class <= CLS_NORMAL;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign  <= operand[31];
                s1_exp   <= op_exp;
                s1_man   <= op_man;
                s1_lzc   <= lzc23(op_man);
                s1_class <= d_class;
            end
        end
    end

    logic [5:0]           sub_shift;
    logic [31:0]          n_fraction;
    logic [EXP_WIDTH-1:0] n_exponent;
    logic                 n_zero, n_sub, n_inf, n_nan, n_snan;

    // A subnormal shifts one extra place: its hidden bit is 0, so the leading one lands on bit 30.
    assign sub_shift = {1'b0, s1_lzc} + 6'd1;

    always_comb begin
        n_fraction = {2'b01, s1_man, 7'b0};
        n_exponent = {{(EXP_WIDTH-8){1'b0}}, s1_exp} - BIAS;
        n_zero     = 1'b0;
        n_sub      = 1'b0;
        n_inf      = 1'b0;
        n_nan      = 1'b0;
        n_snan     = 1'b0;
        unique case (s1_class)
            CLS_ZERO: begin
                n_fraction = '0;
                n_exponent = '0;
                n_zero     = 1'b1;
            end
            CLS_SUB: begin
                n_fraction = {2'b00, s1_man, 7'b0} << sub_shift;
                n_exponent = -BIAS - {{(EXP_WIDTH-5){1'b0}}, s1_lzc};
                n_sub      = 1'b1;
            end
            CLS_INF: begin
                n_fraction = 32'h4000_0000;
                n_exponent = EXP_MAX;
                n_inf      = 1'b1;
            end
            CLS_NAN: begin
                n_exponent = EXP_MAX;
                n_nan      = 1'b1;
                n_snan     = !s1_man[22];
            end
            default: ;
        endcase
    end

    // NOTE: the output data registers are reset too, because downstream expects zeros out of reset, not just out_valid=0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid     <= 1'b0;
            sign         <= 1'b0;
            exponent     <= '0;
            fraction     <= '0;
            is_zero      <= 1'b0;
            is_subnormal <= 1'b0;
            is_inf       <= 1'b0;
            is_nan       <= 1'b0;
            is_snan      <= 1'b0;
        end else if (s2_advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                sign         <= s1_sign;
                exponent     <= n_exponent;
                fraction     <= n_fraction;
                is_zero      <= n_zero;
                is_subnormal <= n_sub;
                is_inf       <= n_inf;
                is_nan       <= n_nan;
                is_snan      <= n_snan;
            end
        end
    end

endmodule
